// File: rtl/store_buffer.sv
// Store buffer: DEPTH-entry in-order store FIFO in front of a single-port data memory.
// Define STORE_BUFFER_FWD_EN to forward full-word store data to matching full-word loads.
module store_buffer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned FWD_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

  state_e state_q, state_d;

  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0] wr_idx, rd_idx;
  logic [PtrW:0]   count;
  logic            empty, full;

  logic [31:0] ent_addr_q [DEPTH];
  logic [31:0] ent_data_q [DEPTH];
  logic [3:0]  ent_mask_q [DEPTH];

  logic            is_load, is_store;
  logic            load_active, load_pending, fwd_hit;
  logic            push, pop, load_complete;
  logic            match;
  logic [PtrW-1:0] youngest_idx;

  logic        op_load_q, op_load_d;
  logic        load_done_q;
  logic [31:0] read_data_q;

  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [3:0]  mem_mask_q, mem_mask_d;

  // FIFO bookkeeping; the extra pointer bit separates full from empty.
  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];
  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);

  // A simultaneous read and write request is a load.
  assign is_load  = cpu_memread;
  assign is_store = cpu_memwrite && !cpu_memread;

  // load_done_q marks the cycle in which a finished load is still on the bus.
  assign load_active = is_load && !load_done_q;

  // Walk entries oldest to youngest so the last hit is the youngest match.
  always_comb begin
    match        = 1'b0;
    youngest_idx = rd_idx;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (((PtrW + 1)'(i) < count) &&
          (ent_addr_q[rd_idx + PtrW'(i)][FWD_ADDR_BITS+1:2] == cpu_addr[FWD_ADDR_BITS+1:2]))
      begin
        match        = 1'b1;
        youngest_idx = rd_idx + PtrW'(i);
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit = load_active && !op_load_q && match &&
                   ent_mask_q[youngest_idx][2] && cpu_sign_mask[2];
`else
  assign fwd_hit = 1'b0;
`endif

  assign load_pending  = load_active && !fwd_hit;
  assign push          = is_store && !full;
  assign pop           = (state_q == StBusy) && !mem_clk_stall && !op_load_q;
  assign load_complete = (state_q == StBusy) && !mem_clk_stall && op_load_q;

  // Reset gating keeps the stall low while reset_n is asserted.
  assign cpu_stall = reset_n && ((is_store && full) || load_active);

  always_comb begin
    state_d     = state_q;
    op_load_d   = op_load_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_mask_d  = '0;
    unique case (state_q)
      StIdle: begin
        // Loads bypass queued stores unless one of them targets the same word.
        if (load_pending && !match) begin
          state_d    = StIssue;
          op_load_d  = 1'b1;
          mem_re_d   = 1'b1;
          mem_addr_d = cpu_addr;
          mem_mask_d = cpu_sign_mask;
        end else if (!empty) begin
          state_d     = StIssue;
          op_load_d   = 1'b0;
          mem_we_d    = 1'b1;
          mem_addr_d  = ent_addr_q[rd_idx];
          mem_wdata_d = ent_data_q[rd_idx];
          mem_mask_d  = ent_mask_q[rd_idx];
        end
      end
      StIssue: state_d = StBusy;
      StBusy: begin
        if (!mem_clk_stall) begin
          state_d   = StIdle;
          op_load_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      op_load_q   <= 1'b0;
      load_done_q <= 1'b0;
      read_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_load_q   <= op_load_d;
      load_done_q <= load_complete || fwd_hit;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_mask_q  <= mem_mask_d;
      if (push) wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
      if (load_complete) begin
        read_data_q <= mem_read_data;
      end else if (fwd_hit) begin
        read_data_q <= ent_data_q[youngest_idx];
      end
    end
  end

  // Entry storage needs no reset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_idx] <= cpu_addr;
      ent_data_q[wr_idx] <= cpu_write_data;
      ent_mask_q[wr_idx] <= cpu_sign_mask;
    end
  end

  assign cpu_read_data  = read_data_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_memwrite   = mem_we_q;
  assign mem_memread    = mem_re_q;
  assign mem_sign_mask  = mem_mask_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: program-order memory model, random and directed traffic.
module tb_store_buffer;

  localparam int Bound = 300;

  logic        clk;
  logic        reset_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_write_data;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  store_buffer #(
    .DEPTH        (4),
    .FWD_ADDR_BITS(10)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_addr      (cpu_addr),
    .cpu_write_data(cpu_write_data),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_memread   (cpu_memread),
    .cpu_sign_mask (cpu_sign_mask),
    .cpu_read_data (cpu_read_data),
    .cpu_stall     (cpu_stall),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_sign_mask (mem_sign_mask),
    .mem_read_data (mem_read_data),
    .mem_clk_stall (mem_clk_stall)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  st_t         exp_st[$];
  logic [31:0] exp_ld[$];
  bit          op_log[$];  // 1 = write reached memory, 0 = read
  logic [31:0] ref_mem [1024];
  logic [31:0] mem [1024];
  int          n_checks = 0;
  int          n_pass = 0;
  int          idle_bad = 0;
  int          stall_mode = 0;  // 0 never, 1 always, 2 random

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: no completion within %0d cycles, completion required", name, Bound);
  endtask

  // Write merge: word, halfword lane addr[1], or byte lane addr[1:0].
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = old;
    if (m[2]) w = d;
    else if (m[1]) w[a[1]*16 +: 16] = d[15:0];
    else w[a[1:0]*8 +: 8] = d[7:0];
    return w;
  endfunction

  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0: mem_clk_stall = 1'b0;
      1: mem_clk_stall = 1'b1;
      default: mem_clk_stall = 1'($urandom_range(0, 1));
    endcase
  end

  // Memory responder and store-order monitor.
  st_t st_cur;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_memwrite && mem_memread) idle_bad++;
      if (mem_memwrite) begin
        op_log.push_back(1'b1);
        if (exp_st.size() == 0) begin
          n_checks++;
          $display("FAIL store_extra: got write to 0x%0h, expected no write", mem_addr);
        end else begin
          st_cur = exp_st.pop_front();
          check("store_order", {mem_addr, mem_write_data, mem_sign_mask},
                {st_cur.a, st_cur.d, st_cur.m});
        end
        mem[mem_addr[11:2]] = merge(mem[mem_addr[11:2]], mem_addr, mem_write_data,
                                    mem_sign_mask);
      end
      if (mem_memread) begin
        op_log.push_back(1'b0);
        mem_read_data = mem[mem_addr[11:2]];
      end
      if (!mem_memwrite && !mem_memread &&
          (mem_addr != 0 || mem_write_data != 0 || mem_sign_mask != 0)) idle_bad++;
    end
  end

  // Load-result monitor: a presented load with stall low is complete.
  logic [31:0] ld_exp;
  always @(negedge clk) begin
    if (reset_n && cpu_memread && !cpu_stall) begin
      if (exp_ld.size() == 0) begin
        n_checks++;
        $display("FAIL load_extra: got completion 0x%0h, expected none", cpu_read_data);
      end else begin
        ld_exp = exp_ld.pop_front();
        check("load_data", cpu_read_data, ld_exp);
      end
    end
  end

  task automatic clear_cpu();
    cpu_addr = '0;
    cpu_write_data = '0;
    cpu_memwrite = 1'b0;
    cpu_memread = 1'b0;
    cpu_sign_mask = '0;
  endtask

  // Tasks start and end at posedge+1.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int stalls);
    st_t s;
    int  cyc;
    cyc = 0;
    cpu_addr = a;
    cpu_write_data = d;
    cpu_sign_mask = m;
    cpu_memwrite = 1'b1;
    cpu_memread = 1'b0;
    @(negedge clk);
    while (cpu_stall && cyc < Bound) begin
      cyc++;
      @(negedge clk);
    end
    stalls = cyc;
    if (cpu_stall) fail_timeout("store_accept");
    else begin
      ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], a, d, m);
      s.a = a;
      s.d = d;
      s.m = m;
      exp_st.push_back(s);
    end
    @(posedge clk);
    #1;
    clear_cpu();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m, input logic both,
                         output int stalls);
    int cyc;
    cyc = 0;
    exp_ld.push_back(ref_mem[a[11:2]]);
    cpu_addr = a;
    cpu_write_data = 32'h0BAD_0BAD;
    cpu_sign_mask = m;
    cpu_memread = 1'b1;
    cpu_memwrite = both;
    @(negedge clk);
    while (cpu_stall && cyc < Bound) begin
      cyc++;
      @(negedge clk);
    end
    stalls = cyc;
    if (cpu_stall) fail_timeout("load_complete");
    @(posedge clk);
    #1;
    clear_cpu();
  endtask

  task automatic set_stall(input int mode);
    @(posedge clk);
    stall_mode = mode;
    #1;
  endtask

  task automatic drain_wait();
    int cyc;
    cyc = 0;
    stall_mode = 0;
    while (exp_st.size() != 0 && cyc < Bound) begin
      @(posedge clk);
      cyc++;
    end
    if (exp_st.size() != 0) fail_timeout("drain");
    repeat (6) @(posedge clk);
    #1;
  endtask

  int          st, st2, st3;
  int unsigned r, k;
  logic [31:0] a;
  logic [3:0]  m;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
    clear_cpu();
    mem_read_data = '0;
    mem_clk_stall = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    cpu_memread = 1'b1;
    #2;
    check("reset_outputs", {cpu_stall, cpu_read_data, mem_addr, mem_write_data, mem_memwrite,
          mem_memread, mem_sign_mask}, '0);
    clear_cpu();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Store then load of the same word.
    op_log.delete();
    do_store(32'h1004, 32'hDEAD_BEEF, 4'b0100, st);
    check("first_store_no_stall", st, 0);
    do_load(32'h1004, 4'b0100, 1'b0, st);
    check("raw_read_data", cpu_read_data, 32'hDEAD_BEEF);
    repeat (4) @(posedge clk);
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check("raw_stall_cycles", st, 1);
    check("raw_mem_ops", op_log.size(), 1);
`else
    check("raw_stall_cycles", st, 6);
    check("raw_mem_ops", op_log.size(), 2);
`endif
    drain_wait();

    // Five stores against a stalled memory.
    set_stall(1);
    for (int i = 0; i < 4; i++) do_store(32'h1100 + i * 4, 32'hA000_0000 + i, 4'b0100, st);
    fork
      do_store(32'h1110, 32'hA000_0004, 4'b0100, st);
      begin
        repeat (6) @(posedge clk);
        stall_mode = 0;
      end
    join
    check("fifth_store_stalled", st != 0, 1'b1);
    drain_wait();

    // Byte store then word load of the containing word.
    op_log.delete();
    do_store(32'h1001, 32'h0000_00AA, 4'b0001, st);
    do_load(32'h1000, 4'b0100, 1'b0, st);
    check("byte_merge", cpu_read_data[15:8], 8'hAA);
    check("byte_drain_first", {op_log.size() >= 2, op_log.size() >= 2 ? op_log[1] : 1'b1,
          op_log.size() >= 1 ? op_log[0] : 1'b0}, 3'b101);
    drain_wait();

    // Non-matching load overtakes two queued stores.
    set_stall(1);
    do_store(32'h1008, 32'h1111_1111, 4'b0100, st);
    do_store(32'h1000, 32'h2222_2222, 4'b0100, st);
    do_store(32'h1004, 32'h3333_3333, 4'b0100, st);
    @(posedge clk);
    stall_mode = 0;
    @(posedge clk);
    #1;
    op_log.delete();
    do_load(32'h1800, 4'b0100, 1'b0, st);
    check("bypass_latency", st, 3);
    check("bypass_read_first", {op_log.size() >= 1, op_log.size() >= 1 ? op_log[0] : 1'b1},
          2'b10);
    drain_wait();

    // Push and pop on the same edge at occupancy DEPTH-1.
    set_stall(1);
    do_store(32'h1020, 32'h5000_0001, 4'b0100, st);
    do_store(32'h1024, 32'h5000_0002, 4'b0100, st);
    do_store(32'h1028, 32'h5000_0003, 4'b0100, st);
    @(posedge clk);
    stall_mode = 0;
    #1;
    fork
      do_store(32'h102C, 32'h5000_0004, 4'b0100, st);
      begin
        @(posedge clk);
        stall_mode = 1;
      end
    join
    do_store(32'h1030, 32'h5000_0005, 4'b0100, st2);
    fork
      do_store(32'h1034, 32'h5000_0006, 4'b0100, st3);
      begin
        repeat (5) @(posedge clk);
        stall_mode = 0;
      end
    join
    check("pushpop_accept", st, 0);
    check("after_pushpop_accept", st2, 0);
    check("after_pushpop_full", st3 != 0, 1'b1);
    drain_wait();

    // Reset while a store is in flight and three are queued.
    set_stall(1);
    for (int i = 0; i < 4; i++) do_store(32'h1040 + i * 4, 32'h7000_0000 + i, 4'b0100, st);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midreset_outputs", {cpu_stall, cpu_read_data, mem_addr, mem_write_data, mem_memwrite,
          mem_memread, mem_sign_mask}, '0);
    op_log.delete();
    exp_st.delete();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    stall_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no_write_after_reset", op_log.size(), 0);
    do_store(32'h1050, 32'h0123_4567, 4'b0100, st);
    check("store_after_reset", st, 0);
    drain_wait();

    // Random traffic.
    stall_mode = 2;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 2);
      a = 32'h1000 + ($urandom_range(0, 5) << 2);
      if (r < 55) begin
        if (k == 0) m = 4'b0100;
        else if (k == 1) begin
          m = 4'b0010;
          a[1] = 1'($urandom_range(0, 1));
        end else begin
          m = 4'b0001;
          a[1:0] = 2'($urandom_range(0, 3));
        end
        do_store(a, $urandom, m, st);
      end else begin
        if (k == 2) begin
          m = 4'b0001;
          a[1:0] = 2'($urandom_range(0, 3));
        end else m = 4'b0100;
        do_load(a, m, 1'($urandom_range(0, 9) == 0), st);
      end
      if ($urandom_range(0, 7) == 0) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    drain_wait();

    check("loads_outstanding", exp_ld.size(), 0);
    check("stores_outstanding", exp_st.size(), 0);
    check("mem_idle_zero", idle_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
